rx_buffer: RTL

RX_BUFFER -- requirements
Module: rx_buffer

---
 rtl/rx_pkg.sv | 18 +
 rtl/rx_buffer_ram.sv | 34 +++
 rtl/rx_buffer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// Shared widths and types for the RX sample buffer.
// RX_BUFFER_DROP_CNT_EN selects the dropped-sample counter in rx_buffer.
package rx_pkg;

    localparam int SAMPLE_W   = 64;
    localparam int WORD_W     = 32;
    localparam int DROP_CNT_W = 16;

    typedef logic [SAMPLE_W-1:0]   sample_t;
    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    // Each sample is served low word first, then high word.
    function automatic word_t sel_word(input sample_t s, input logic hi);
        return hi ? s[SAMPLE_W-1:WORD_W] : s[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/rx_buffer_ram.sv
// Simple dual-port sample storage with a registered read port.
// Storage is never reset; only the read register is, so nothing stale leaks out.
module rx_buffer_ram
    import rx_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  sample_t           wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output sample_t           rd_data
);

    sample_t mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rx_buffer.sv
// RX sample FIFO: 64-bit {I,Q} samples in, 32-bit words out on read strobes.
// Define RX_BUFFER_DROP_CNT_EN to add the saturating drop_cnt_o counter.
module rx_buffer
    import rx_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  sample_t           axis_tdata_i,
    input  logic              axis_tvalid_i,
    output logic              axis_tready_o,
    input  logic              rd_i,
    output word_t             rd_data_o,
    output logic              rd_valid_o,
    input  logic              clr_i,
    output logic [ADDR_W+1:0] words_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o,
`ifdef RX_BUFFER_DROP_CNT_EN
    output drop_cnt_t         drop_cnt_o,
`endif
    output logic              underflow_o
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              half;
    logic              sel_hi;
    sample_t           ram_q;

    logic push;
    logic drop;
    logic rd_ok;
    logic pop;

    // Status comes only from the registered count, so a pop frees a slot next cycle.
    assign full_o        = (count == CNT_W'(DEPTH));
    assign empty_o       = (count == '0);
    assign axis_tready_o = !full_o;
    assign words_o       = {count, 1'b0} - {{CNT_W{1'b0}}, half};

    assign push  = axis_tvalid_i && !full_o && !clr_i;
    assign drop  = axis_tvalid_i && full_o && !clr_i;
    assign rd_ok = rd_i && !empty_o && !clr_i;
    assign pop   = rd_ok && half;

    rx_buffer_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data (axis_tdata_i),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    // RAM output and sel_hi only move on a real read, so rd_data_o holds otherwise.
    assign rd_data_o = sel_word(ram_q, sel_hi);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            half        <= 1'b0;
            sel_hi      <= 1'b0;
            rd_valid_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (clr_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            half        <= 1'b0;
            rd_valid_o  <= 1'b0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_ok;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                sel_hi <= half;
                half   <= !half;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow_o <= 1'b1;
            end
            if (rd_i && empty_o) begin
                underflow_o <= 1'b1;
            end
        end
    end

`ifdef RX_BUFFER_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_o <= '0;
        end else if (clr_i) begin
            drop_cnt_o <= '0;
        end else if (drop && (drop_cnt_o != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end
`endif

endmodule
